sample_mixer_player: RTL and testbench

- Parametrised successor to the single-clip playback block.
- Plays up to NUM_VOICES independent clips from one shared sample ROM. Each voice is triggered with its own start address, length and loop mode.
- Sums all active voices into one signed output on every sample tick, with saturation.
- Sits between the game-event logic (triggers) and the audio PWM/DAC stage (audio_out).

---
 rtl/sample_mixer_player.sv | 217 +++++++++++++++++++++
 tb/tb_sample_mixer_player.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_mixer_player.sv
// rtl/sample_mixer_player.sv - multi-voice clip player mixing samples from one shared ROM
// Per-voice gain is compiled in when SAMPLE_MIXER_GAIN_EN is defined.
module sample_mixer_player #(
    parameter int    NUM_VOICES   = 4,
    parameter int    SAMPLE_WIDTH = 8,
    parameter int    ADDR_WIDTH   = 16,
    parameter string INIT_FILE    = ""
) (
    input  logic                                                   clk_in,
    input  logic                                                   rst_n_in,
    input  logic                                                   sample_tick_in,
    input  logic                                                   trig_valid_in,
    input  logic [((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1)-1:0] trig_voice_in,
    input  logic [ADDR_WIDTH-1:0]                                  trig_start_in,
    input  logic [ADDR_WIDTH-1:0]                                  trig_len_in,
    input  logic                                                   trig_loop_in,
`ifdef SAMPLE_MIXER_GAIN_EN
    input  logic [3:0]                                             trig_gain_in,
`endif
    input  logic [NUM_VOICES-1:0]                                  stop_mask_in,
    output logic [NUM_VOICES-1:0]                                  voice_active_out,
    output logic signed [SAMPLE_WIDTH-1:0]                         audio_out,
    output logic                                                   audio_valid_out,
    output logic                                                   overrun_out
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
`ifdef SAMPLE_MIXER_GAIN_EN
    localparam int LAT = 3;
    localparam int AW  = SAMPLE_WIDTH + $clog2(NUM_VOICES) + 2;
`else
    localparam int LAT = 2;
    localparam int AW  = SAMPLE_WIDTH + $clog2(NUM_VOICES) + 1;
`endif
    localparam logic signed [AW-1:0] SAT_MAX = AW'({(SAMPLE_WIDTH-1){1'b1}});
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;

    state_t                         state_q, state_d;
    logic [VW-1:0]                  idx_q, idx_d;
    logic [1:0]                     cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]          start_q [NUM_VOICES];
    logic [ADDR_WIDTH-1:0]          start_d [NUM_VOICES];
    logic [ADDR_WIDTH-1:0]          len_q   [NUM_VOICES];
    logic [ADDR_WIDTH-1:0]          len_d   [NUM_VOICES];
    logic [ADDR_WIDTH-1:0]          off_q   [NUM_VOICES];
    logic [ADDR_WIDTH-1:0]          off_d   [NUM_VOICES];
    logic [NUM_VOICES-1:0]          loop_q, loop_d, active_q, active_d;
    logic [LAT-1:0]                 flag_q, flag_d;
    logic signed [AW-1:0]           acc_q, acc_d, samp_ext;
    logic signed [SAMPLE_WIDTH-1:0] audio_q, audio_d;
    logic                           valid_q, valid_d, overrun_q, overrun_d;
    logic [ADDR_WIDTH-1:0]          rom_addr;
    logic [SAMPLE_WIDTH-1:0]        rom_mem [2**ADDR_WIDTH];
    logic [SAMPLE_WIDTH-1:0]        rom_rd_q, rom_dout_q;

    // Contents are loaded from INIT_FILE by the implementation flow's memory initialisation.
    if (INIT_FILE != "") begin : g_init_file
    end

    // Two-stage BRAM read: address register plus output register.
    always_ff @(posedge clk_in) begin
        rom_rd_q   <= rom_mem[rom_addr];
        rom_dout_q <= rom_rd_q;
    end

`ifdef SAMPLE_MIXER_GAIN_EN
    logic [3:0]                     gain_q [NUM_VOICES];
    logic [3:0]                     gain_d [NUM_VOICES];
    logic [3:0]                     gp0_q, gp0_d, gp1_q, gp1_d;
    logic signed [SAMPLE_WIDTH+4:0] prod;
    logic signed [SAMPLE_WIDTH+1:0] scaled_q, scaled_d;

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            gain_d[v] = gain_q[v];
            if (trig_valid_in && trig_len_in != '0 && trig_voice_in == VW'(v)) begin
                gain_d[v] = trig_gain_in;
            end
        end
        gp0_d    = gain_q[idx_q];
        gp1_d    = gp0_q;
        prod     = $signed(rom_dout_q) * $signed({1'b0, gp1_q});
        scaled_d = (SAMPLE_WIDTH+2)'(prod >>> 3);
        samp_ext = AW'(scaled_q);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int v = 0; v < NUM_VOICES; v++) gain_q[v] <= 4'd8;
            gp0_q    <= '0;
            gp1_q    <= '0;
            scaled_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) gain_q[v] <= gain_d[v];
            gp0_q    <= gp0_d;
            gp1_q    <= gp1_d;
            scaled_q <= scaled_d;
        end
    end
`else
    always_comb begin
        samp_ext = AW'($signed(rom_dout_q));
    end
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        audio_d   = audio_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        rom_addr  = start_q[idx_q] + off_q[idx_q];
        flag_d    = {flag_q[LAT-2:0], (state_q == READ) && active_q[idx_q]};
        acc_d     = acc_q + (flag_q[LAT-1] ? samp_ext : '0);
        if (sample_tick_in && state_q != IDLE) overrun_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (sample_tick_in) begin
                    state_d = READ;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            READ: begin
                if (idx_q == VW'(NUM_VOICES-1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    idx_d = idx_q + VW'(1);
                end
            end
            DRAIN: begin
                // The last voice's sample lands in acc_d this cycle, so saturate that.
                if (cnt_q == 2'(LAT-1)) begin
                    state_d = OUT;
                    valid_d = 1'b1;
                    if (acc_d > SAT_MAX)      audio_d = SAT_MAX[SAMPLE_WIDTH-1:0];
                    else if (acc_d < SAT_MIN) audio_d = SAT_MIN[SAMPLE_WIDTH-1:0];
                    else                      audio_d = acc_d[SAMPLE_WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Priority per voice: trigger, then stop, then pointer advance.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            start_d[v]  = start_q[v];
            len_d[v]    = len_q[v];
            off_d[v]    = off_q[v];
            loop_d[v]   = loop_q[v];
            active_d[v] = active_q[v];
            if (state_q == READ && idx_q == VW'(v) && active_q[v]) begin
                if (off_q[v] == len_q[v] - ADDR_WIDTH'(1)) begin
                    off_d[v]    = '0;
                    active_d[v] = loop_q[v];
                end else begin
                    off_d[v] = off_q[v] + ADDR_WIDTH'(1);
                end
            end
            if (stop_mask_in[v]) active_d[v] = 1'b0;
            if (trig_valid_in && trig_len_in != '0 && trig_voice_in == VW'(v)) begin
                start_d[v]  = trig_start_in;
                len_d[v]    = trig_len_in;
                off_d[v]    = '0;
                loop_d[v]   = trig_loop_in;
                active_d[v] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            audio_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            flag_q    <= '0;
            loop_q    <= '0;
            active_q  <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                start_q[v] <= '0;
                len_q[v]   <= '0;
                off_q[v]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            audio_q   <= audio_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            flag_q    <= flag_d;
            loop_q    <= loop_d;
            active_q  <= active_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                start_q[v] <= start_d[v];
                len_q[v]   <= len_d[v];
                off_q[v]   <= off_d[v];
            end
        end
    end

    assign voice_active_out = active_q;
    assign audio_out        = audio_q;
    assign audio_valid_out  = valid_q;
    assign overrun_out      = overrun_q;
endmodule

// File: tb/tb_sample_mixer_player.sv
// tb/tb_sample_mixer_player.sv - scoreboard bench for sample_mixer_player with a per-tick clip model
module tb_sample_mixer_player;
    localparam int NV = 4;
`ifdef SAMPLE_MIXER_GAIN_EN
    localparam int OUT_LAT = NV + 4;
`else
    localparam int OUT_LAT = NV + 3;
`endif

    logic              clk = 1'b0;
    logic              rst_n, tick, trig_valid, trig_loop;
    logic [1:0]        trig_voice;
    logic [15:0]       trig_start, trig_len;
    logic [3:0]        stop_mask, voice_active;
    logic signed [7:0] audio;
    logic              audio_valid, overrun;

    always #5 clk = ~clk;

    sample_mixer_player #(.NUM_VOICES(NV), .SAMPLE_WIDTH(8), .ADDR_WIDTH(16), .INIT_FILE("")) dut (
        .clk_in(clk), .rst_n_in(rst_n), .sample_tick_in(tick),
        .trig_valid_in(trig_valid), .trig_voice_in(trig_voice), .trig_start_in(trig_start),
        .trig_len_in(trig_len), .trig_loop_in(trig_loop),
`ifdef SAMPLE_MIXER_GAIN_EN
        .trig_gain_in(4'd8),
`endif
        .stop_mask_in(stop_mask), .voice_active_out(voice_active), .audio_out(audio),
        .audio_valid_out(audio_valid), .overrun_out(overrun)
    );

    typedef struct {
        int val;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   rom_m [65536];
    int   m_start[NV], m_len[NV], m_off[NV];
    bit   m_loop[NV], m_act[NV];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (audio_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_valid: pulse at cycle %0d, required none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("audio", int'(audio), e.val);
                check("valid_cycle", cyc, e.at);
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rom_wr(int a, int v);
        dut.rom_mem[a] = 8'(v);
        rom_m[a] = v;
    endtask

    task automatic model_trig(int v, int st, int ln, bit lp);
        if (ln != 0) begin
            m_start[v] = st; m_len[v] = ln; m_off[v] = 0; m_loop[v] = lp; m_act[v] = 1'b1;
        end
    endtask

    task automatic model_stop(logic [3:0] sm);
        for (int v = 0; v < NV; v++) if (sm[v]) m_act[v] = 1'b0;
    endtask

    // One sample tick: every playing voice contributes its current sample, then steps on.
    function automatic int model_mix();
        int s = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_act[v]) begin
                s += rom_m[(m_start[v] + m_off[v]) % 65536];
                m_off[v]++;
                if (m_off[v] == m_len[v]) begin
                    m_off[v] = 0;
                    m_act[v] = m_loop[v];
                end
            end
        end
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    function automatic logic [3:0] model_mask();
        logic [3:0] m;
        for (int v = 0; v < NV; v++) m[v] = m_act[v];
        return m;
    endfunction

    task automatic push_exp(int val, int at);
        exp_t e;
        e.val = val;
        e.at  = at;
        exp_q.push_back(e);
    endtask

    task automatic tick_wait();
        int e;
        tick = 1'b1;
        e = model_mix();
        push_exp(e, cyc + OUT_LAT);
        step(1);
        tick = 1'b0;
        step(11);
        check("voice_active", int'(voice_active), int'(model_mask()));
        check("audio_hold", int'(audio), e);
    endtask

    task automatic drive_trig(int v, int st, int ln, bit lp, logic [3:0] sm);
        trig_valid = 1'b1; trig_voice = 2'(v); trig_start = 16'(st);
        trig_len = 16'(ln); trig_loop = lp; stop_mask = sm;
        step(1);
        trig_valid = 1'b0; stop_mask = '0;
    endtask

    task automatic trig(int v, int st, int ln, bit lp);
        drive_trig(v, st, ln, lp, 4'b0000);
        model_trig(v, st, ln, lp);
    endtask

    task automatic stop(logic [3:0] sm);
        stop_mask = sm;
        step(1);
        stop_mask = '0;
        model_stop(sm);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         tc, e, rv, rs, rl;
        bit         rlp;
        logic [3:0] rm;
        rst_n = 1'b0; tick = 1'b0; trig_valid = 1'b0; trig_voice = '0;
        trig_start = '0; trig_len = '0; trig_loop = 1'b0; stop_mask = '0;
        rom_wr(100, 10); rom_wr(101, 20); rom_wr(102, 30);
        rom_wr(200, 100); rom_wr(201, -100);
        for (int a = 300; a < 330; a++) rom_wr(a, int'($urandom_range(0, 255)) - 128);
        step(3);
        rst_n = 1'b1;
        step(1);
        check("rst_audio", int'(audio), 0);
        check("rst_valid", int'(audio_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_active", int'(voice_active), 0);

        repeat (2) begin
            tick_wait();
            step(8);
        end

        trig(0, 100, 3, 0);
        repeat (4) tick_wait();

        trig(0, 100, 3, 1);
        repeat (5) tick_wait();
        stop(4'b0001);
        tick_wait();

        for (int v = 0; v < NV; v++) trig(v, 200, 1, 1);
        tick_wait();
        for (int v = 0; v < NV; v++) trig(v, 201, 1, 1);
        tick_wait();
        stop(4'b1111);

        // Retriggers inside a sweep: voice0 at its own read cycle, voice2 before its read.
        trig(0, 100, 3, 1);
        trig(1, 101, 2, 1);
        tick_wait();
        tick = 1'b1; tc = cyc;
        step(1);
        tick = 1'b0;
        drive_trig(0, 102, 1, 0, 4'b0000);
        drive_trig(2, 100, 2, 1, 4'b0000);
        model_trig(2, 100, 2, 1);
        e = model_mix();
        model_trig(0, 102, 1, 0);
        push_exp(e, tc + OUT_LAT);
        step(9);
        check("active_after_midsweep", int'(voice_active), int'(model_mask()));
        tick_wait();
        trig(3, 100, 0, 1);
        trig(2, 200, 0, 0);
        check("len0_ignored", int'(voice_active), int'(model_mask()));
        tick_wait();
        stop(4'b1111);

        check("overrun_pre", int'(overrun), 0);
        trig(0, 100, 3, 1);
        tick = 1'b1; tc = cyc;
        e = model_mix();
        push_exp(e, tc + OUT_LAT);
        step(1);
        tick = 1'b0;
        step(2);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(10);
        check("overrun_set", int'(overrun), 1);
        tick_wait();
        check("overrun_sticky", int'(overrun), 1);

        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(2);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        for (int v = 0; v < NV; v++) begin
            m_act[v] = 1'b0; m_off[v] = 0;
        end
        step(10);
        check("midreset_audio", int'(audio), 0);
        check("midreset_overrun", int'(overrun), 0);
        check("midreset_active", int'(voice_active), 0);

        for (int i = 0; i < 40; i++) begin
            repeat (2) begin
                rv  = int'($urandom_range(0, 3));
                rs  = 300 + int'($urandom_range(0, 20));
                rl  = int'($urandom_range(0, 4));
                rlp = 1'($urandom_range(0, 1));
                rm  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
                drive_trig(rv, rs, rl, rlp, rm);
                model_stop(rm);
                model_trig(rv, rs, rl, rlp);
            end
            tick_wait();
            step(int'($urandom_range(0, 4)));
        end

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) step(1);
        check("pending_expected", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
